// File: rtl/instr_prefetch_unit_if.sv
// Bus bundle for the instruction prefetch unit.
//   imem_req_*  : fetch request channel to instruction memory (valid/ready)
//   imem_rsp_*  : in-order response channel from memory (no backpressure)
//   redirect*   : branch/jump redirect from decode
//   if_*        : instruction + PC+4 handoff to decode (valid/ready)
// master = prefetch unit side, slave = memory/decode side.
interface instr_prefetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;

  modport master (
    output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_prefetch_unit.sv
// Fetch-stage front end. Owns the PC, issues word fetches to a variable
// latency instruction memory, buffers returned words in a DEPTH-entry FIFO
// and hands {instruction, PC+4} to decode. Redirects flush the FIFO and
// drop every response still in flight.
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-low reset
//   bus  - instr_prefetch_unit_if.master (imem request/response, redirect,
//          decode handoff)
module instr_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                   Clk,
  input logic                   Rst,
  instr_prefetch_unit_if.master bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_outst;
  logic [CW-1:0] r_discard;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_tag_rd;
  logic [AW-1:0] r_tag_wr;
  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc4   [DEPTH];
  logic [31:0]   r_tag   [DEPTH];

  logic [CW:0]   w_used;
  logic          w_req_valid;
  logic          w_fire;
  logic          w_rsp;
  logic          w_drop;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic [CW-1:0] w_outst_nxt;
  logic [CW-1:0] w_discard_nxt;
  logic          w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = ^bus.redirect_pc[1:0];

  // Queued plus in-flight words may never exceed DEPTH, so responses can
  // always be accepted without backpressure.
  assign w_used      = {1'b0, r_count} + {1'b0, r_outst};
  assign w_req_valid = Rst && !bus.redirect && (w_used < (CW+1)'(DEPTH));

  always_comb begin
    w_fire        = w_req_valid && bus.imem_req_ready;
    w_rsp         = bus.imem_rsp_valid;
    // A response in the redirect cycle is stale as well
    w_drop        = w_rsp && (bus.redirect || (r_discard != '0));
    w_push        = w_rsp && !w_drop;
    w_pop         = (r_count != '0) && bus.if_ready && !bus.redirect;
    w_outst_nxt   = r_outst + CW'(w_fire) - CW'(w_rsp);
    w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
    w_discard_nxt = r_discard;
    if (bus.redirect) begin
      w_count_nxt   = '0;
      // Everything still outstanding after this cycle's response is stale
      w_discard_nxt = w_outst_nxt;
    end else if (w_rsp && (r_discard != '0)) begin
      w_discard_nxt = r_discard - CW'(1);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_pc      <= RESET_PC;
      r_count   <= '0;
      r_outst   <= '0;
      r_discard <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_tag_rd  <= '0;
      r_tag_wr  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_instr[i] <= '0;
        r_pc4[i]   <= '0;
        r_tag[i]   <= '0;
      end
    end else begin
      r_count   <= w_count_nxt;
      r_outst   <= w_outst_nxt;
      r_discard <= w_discard_nxt;

      if (bus.redirect)
        r_pc <= {bus.redirect_pc[31:2], 2'b00};
      else if (w_fire)
        r_pc <= r_pc + 32'd4;

      // Tag queue tracks the address of every issued request, including
      // those later discarded, so it stays aligned with the response order.
      if (w_fire) begin
        r_tag[r_tag_wr] <= r_pc;
        r_tag_wr        <= r_tag_wr + 1'b1;
      end
      if (w_rsp)
        r_tag_rd <= r_tag_rd + 1'b1;

      if (w_push) begin
        r_instr[r_wr_ptr] <= bus.imem_rsp_data;
        r_pc4[r_wr_ptr]   <= r_tag[r_tag_rd] + 32'd4;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end

      // Flush by catching the read pointer up; no push occurs in a redirect cycle
      if (bus.redirect)
        r_rd_ptr <= r_wr_ptr;
      else if (w_pop)
        r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = r_pc;
  assign bus.if_valid       = (r_count != '0);
  assign bus.if_instr       = r_instr[r_rd_ptr];
  assign bus.if_pc4         = r_pc4[r_rd_ptr];

  a_rsp_needs_outstanding: assert property (@(posedge Clk) disable iff (!Rst)
    bus.imem_rsp_valid |-> (r_outst != '0));
  a_credit_bound: assert property (@(posedge Clk) disable iff (!Rst)
    w_used <= (CW+1)'(DEPTH));
  a_discard_bound: assert property (@(posedge Clk) disable iff (!Rst)
    r_discard <= r_outst);

endmodule

// File: tb/tb_instr_prefetch_unit.sv
module tb_instr_prefetch_unit;
  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic Clk = 1'b0;
  logic Rst;

  instr_prefetch_unit_if bus ();

  instr_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int unsigned due;
    logic [31:0] data;
    int unsigned epoch;
  } rsp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } exp_t;

  rsp_t        pend_q[$];
  exp_t        exp_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned epoch = 0;
  int unsigned rsp_epoch = 0;
  int unsigned m_inflight = 0;
  int unsigned m_queued = 0;
  int unsigned n_deliv = 0;
  logic [31:0] exp_addr = RESET_PC;
  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;

  // Instruction memory contents: a fixed scramble of the word address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F17 ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  initial begin
    rsp_t        r;
    exp_t        e;
    int unsigned d0;

    Rst                = 1'b0;
    bus.redirect       = 1'b0;
    bus.redirect_pc    = '0;
    bus.imem_req_ready = 1'b1;
    bus.if_ready       = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;

    fork
      // Memory: in-order responses, each at least one cycle after acceptance
      forever begin
        @(posedge Clk);
        cyc++;
        #1;
        if (!Rst) begin
          pend_q.delete();
          bus.imem_rsp_valid = 1'b0;
          bus.imem_rsp_data  = '0;
        end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
          r = pend_q.pop_front();
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = r.data;
          rsp_epoch          = r.epoch;
        end else begin
          bus.imem_rsp_valid = 1'b0;
          bus.imem_rsp_data  = $urandom;
        end
      end

      // Monitor + reference model: program-order stream restarted by redirects
      forever begin
        @(negedge Clk);
        if (!Rst) begin
          exp_q.delete();
          m_inflight = 0;
          m_queued   = 0;
          exp_addr   = RESET_PC;
          prev_wait  = 1'b0;
          epoch++;
        end else begin
          chk("req_valid", 32'(bus.imem_req_valid),
              32'(!bus.redirect && (m_queued + m_inflight < DEPTH)));
          chk("if_valid", 32'(bus.if_valid), 32'(m_queued != 0));
          if (prev_wait && !bus.redirect) begin
            chk("hold_valid", 32'(bus.imem_req_valid), 32'd1);
            chk("hold_addr", bus.imem_req_addr, prev_addr);
          end
          if (bus.imem_req_valid && bus.imem_req_ready) begin
            chk("req_addr", bus.imem_req_addr, exp_addr);
            exp_q.push_back('{mem_word(exp_addr), exp_addr + 32'd4});
            pend_q.push_back('{cyc + lat, mem_word(bus.imem_req_addr), epoch});
            m_inflight++;
            exp_addr = exp_addr + 32'd4;
          end
          if (bus.imem_rsp_valid) begin
            if (m_inflight != 0) m_inflight--;
            if (rsp_epoch == epoch && !bus.redirect) m_queued++;
          end
          if (bus.if_valid && bus.if_ready && !bus.redirect) begin
            n_deliv++;
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_bad++;
              $display("FAIL unexpected_deliv: got pc4 %h expected none", bus.if_pc4);
            end else begin
              e = exp_q.pop_front();
              chk("if_instr", bus.if_instr, e.instr);
              chk("if_pc4", bus.if_pc4, e.pc4);
            end
            if (m_queued != 0) m_queued--;
          end
          if (bus.redirect) begin
            exp_q.delete();
            epoch++;
            m_queued = 0;
            exp_addr = {bus.redirect_pc[31:2], 2'b00};
          end
          prev_wait = bus.imem_req_valid && !bus.imem_req_ready && !bus.redirect;
          prev_addr = bus.imem_req_addr;
        end
      end
    join_none

    // Reset values
    #1;
    chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_if_instr", bus.if_instr, 32'd0);
    chk("rst_if_pc4", bus.if_pc4, 32'd0);
    step(3);
    Rst = 1'b1;

    // Streaming at one instruction per cycle
    step(10);
    d0 = n_deliv;
    step(20);
    chk("throughput", n_deliv - d0, 32'd20);

    // Decode stall fills the FIFO and stops fetching
    bus.if_ready = 1'b0;
    step(10);
    chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("stall_if_valid", 32'(bus.if_valid), 32'd1);
    bus.if_ready = 1'b1;
    step(10);

    // Redirect with responses in flight, misaligned target
    lat = 3;
    step(8);
    for (int i = 0; i < 10 && m_inflight != 2; i++) step(1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    step(1);
    bus.redirect    = 1'b0;
    step(15);

    // Memory not ready: address held
    bus.imem_req_ready = 1'b0;
    step(5);
    bus.imem_req_ready = 1'b1;
    step(10);

    // Back-to-back redirects with a response in the first cycle
    lat = 1;
    step(5);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0000_0040;
    step(1);
    bus.redirect_pc = 32'h0000_0080;
    step(1);
    bus.redirect    = 1'b0;
    step(15);

    // Asynchronous reset with queued and outstanding work
    lat          = 2;
    bus.if_ready = 1'b0;
    step(6);
    chk("pre_reset_if_valid", 32'(bus.if_valid), 32'd1);
    @(posedge Clk);
    #3;
    Rst = 1'b0;
    #1;
    chk("async_rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("async_rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    chk("async_rst_if_instr", bus.if_instr, 32'd0);
    chk("async_rst_if_pc4", bus.if_pc4, 32'd0);
    step(3);
    Rst          = 1'b1;
    bus.if_ready = 1'b1;
    step(10);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.imem_req_ready = ($urandom % 4) != 0;
      bus.if_ready       = ($urandom % 3) != 0;
      lat                = 1 + ($urandom % 4);
      bus.redirect       = ($urandom % 32) == 0;
      bus.redirect_pc    = $urandom;
      step(1);
    end

    // Drain: stop accepting fetches, everything expected must come out
    bus.redirect       = 1'b0;
    bus.imem_req_ready = 1'b0;
    bus.if_ready       = 1'b1;
    step(40);
    chk("drain_pending", exp_q.size(), 32'd0);
    chk("drain_if_valid", 32'(bus.if_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_unit.md
Name: instr_prefetch_unit

Overview:
- Fetch stage front end that sits directly upstream of the IF/ID pipeline register.
- Owns the PC and issues word fetches to a variable-latency instruction memory over a valid/ready request port and an in-order response port.
- Buffers returned instructions in a small FIFO and presents {instruction, PC+4} to decode under a valid/ready handshake.
- Handles branch/jump redirects by flushing the FIFO and discarding responses that are still in flight.

Parameters:
- DEPTH, 4, FIFO entries; also the maximum number of queued plus outstanding fetches (power of 2, 2..16).
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst  input  1  asynchronous, active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_rsp_valid  input  1  response valid, in request order, at least 1 cycle after acceptance.
- imem_rsp_data  input  32  fetched instruction.
- redirect  input  1  branch/jump taken (PCsrc from decode).
- redirect_pc  input  32  target address; bits [1:0] are ignored and forced to 0.
- if_valid  output  1  instruction available to decode.
- if_ready  input  1  decode accepts (deasserted on IF/ID stall).
- if_instr  output  32  instruction at FIFO head.
- if_pc4  output  32  address of that instruction + 4.

Behaviour:
- Reset (Rst low, asynchronous):
  - pc <= RESET_PC; FIFO empty; outstanding = 0; discard = 0.
  - imem_req_valid = 0, if_valid = 0, if_instr = 0, if_pc4 = 0.
  - First request may assert in the first cycle after Rst deasserts.
  - Reset mid-operation drops all queued and outstanding state. Responses arriving after reset for pre-reset requests are not masked; the memory must be reset together with this block.
- Credit rule:
  - imem_req_valid = !redirect && (count + outstanding < DEPTH).
  - imem_req_addr = pc.
  - Responses are always accepted; there is no response backpressure and the FIFO can never overflow.
- Request handshake:
  - A request fires when imem_req_valid && imem_req_ready. On fire: pc <= pc + 4 (wraps modulo 2^32) and outstanding += 1.
  - While valid && !ready, addr is held stable.
  - Only exception: a redirect may withdraw an unaccepted request.
- Response:
  - On imem_rsp_valid: outstanding -= 1.
  - If discard > 0: discard -= 1 and the data is dropped.
  - Otherwise push {rsp_data, addr + 4} into the FIFO. The per-request address is tracked in a DEPTH-entry tag queue in issue order.
- Output:
  - if_valid = FIFO not empty; if_instr and if_pc4 come from the head entry (registered, no combinational path from rsp to if_*).
  - Minimum latency is one cycle from rsp_valid to if_valid.
  - Pop when if_valid && if_ready.
  - Push and pop in the same cycle leave count unchanged, including when full or when count = 1.
- Redirect (single-cycle pulse, may repeat back-to-back):
  - In the redirect cycle: FIFO cleared, pc <= {redirect_pc[31:2], 2'b00}, no request issued.
  - discard <= outstanding after this cycle's response is accounted: a response arriving in the redirect cycle is also dropped, and it decrements outstanding rather than adding to discard.
  - Pop in the redirect cycle is ignored; decode flushes IF/ID itself.
  - Requests to the new target issue from the next cycle, subject to credits. Discarded slots free their credit only when their response returns.
- Counters: count and outstanding are each log2(DEPTH)+1 bits wide.
- Assertions:
  - No rsp_valid when outstanding = 0.
  - count + outstanding never exceeds DEPTH.
  - discard never exceeds outstanding.

Test Plan:
- Reset, zero-latency-plus-1 memory with ready = 1, if_ready = 1 → addresses 0x0, 0x4, 0x8… issued one per cycle; if_pc4 sequence 0x4, 0x8, 0xC; if_instr matches memory contents; steady state is one instruction per cycle.
- if_ready = 0 held for 10 cycles → exactly DEPTH = 4 instructions queued, imem_req_valid drops to 0, no request beyond addr 0xC. Releasing if_ready drains 0x0..0xC in order, then fetching resumes at 0x10.
- 3-cycle response latency, 2 requests outstanding, redirect with redirect_pc = 0x0000_0103 → both stale responses dropped; the next if_valid shows if_pc4 = 0x104 with the instruction from address 0x100.
- imem_req_ready = 0 for 5 cycles at addr 0x20 → imem_req_addr stays 0x20 throughout; after ready rises, the next request is 0x24.
- Redirect in two consecutive cycles (targets 0x40, then 0x80), with a response arriving in the first redirect cycle → no instruction from 0x40 or from stale requests is ever delivered; the first delivered if_pc4 is 0x84.
- Rst asserted while FIFO holds 3 entries and 1 fetch is outstanding → if_valid = 0 immediately (asynchronous); after release, the first request address is RESET_PC.
